// File: rtl/rv_m_pkg.sv
// Shared RV32M divider definitions: operation codes, FSM states and iteration timing.
package rv_m_pkg;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = 34;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the core (master) and div_unit (slave).
interface div_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  START;
    logic [1:0]            FUNCT;
    logic [DATA_WIDTH-1:0] DIVIDEND;
    logic [DATA_WIDTH-1:0] DIVISOR;
    logic [ADDR_WIDTH-1:0] RD_IN;
    logic                  BUSY;
    logic                  DONE;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] RD_OUT;
    logic [DATA_WIDTH-1:0] RESULT;

    modport master (
        output START, FUNCT, DIVIDEND, DIVISOR, RD_IN,
        input  BUSY, DONE, WE, RD_OUT, RESULT
    );

    modport slave (
        input  START, FUNCT, DIVIDEND, DIVISOR, RD_IN,
        output BUSY, DONE, WE, RD_OUT, RESULT
    );
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 division iteration on magnitudes (purely combinational).
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);
    logic [DATA_WIDTH:0] shifted_s;
    logic [DATA_WIDTH:0] diff_s;
    logic                ge_s;

    assign shifted_s = {rem, quo[DATA_WIDTH-1]};
    assign ge_s      = (shifted_s >= {1'b0, divisor});
    assign diff_s    = shifted_s - {1'b0, divisor};
    // A kept subtraction always leaves a value below the divisor, so the top bit drops safely.
    assign rem_next  = DATA_WIDTH'(ge_s ? diff_s : shifted_s);
    assign quo_next  = {quo[DATA_WIDTH-2:0], ge_s};
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) feeding the register file write port.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iterations.
module div_unit
    import rv_m_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic     CLK,
    input  logic     RST,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

    div_state_t state_r, state_s;
    logic [DATA_WIDTH-1:0] rem_r, quo_r, dvs_r, result_r;
    logic [DATA_WIDTH-1:0] rem_step_s, quo_step_s, abs_a_s, abs_b_s;
    logic [DATA_WIDTH-1:0] q_fix_s, r_fix_s, fix_sel_s, early_val_s;
    logic [ADDR_WIDTH-1:0] rd_r, rd_out_r;
    logic [1:0]            funct_r;
    logic [CW-1:0]         cnt_r;
    logic neg_a_r, neg_b_r, busy_r, done_r;
    logic neg_a_s, neg_b_s, accept_s, early_s;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // The DONE pulse cycle is still IDLE in the state register, so block acceptance there.
    assign accept_s = (state_r == S_IDLE) && bus.START && !done_r;
    assign neg_a_s  = !bus.FUNCT[0] && bus.DIVIDEND[DATA_WIDTH-1];
    assign neg_b_s  = !bus.FUNCT[0] && bus.DIVISOR[DATA_WIDTH-1];
    assign abs_a_s  = neg_a_s ? -bus.DIVIDEND : bus.DIVIDEND;
    assign abs_b_s  = neg_b_s ? -bus.DIVISOR  : bus.DIVISOR;

`ifdef DIV_EARLY_OUT_EN
    localparam logic [DATA_WIDTH-1:0] ALL1  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_S = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic zero_s, ovf_s;
    assign zero_s  = (bus.DIVISOR == ZERO);
    assign ovf_s   = !bus.FUNCT[0] && (bus.DIVIDEND == MIN_S) && (bus.DIVISOR == ALL1);
    assign early_s = zero_s || ovf_s;
    assign early_val_s = zero_s ? (bus.FUNCT[1] ? bus.DIVIDEND : ALL1)
                                : (bus.FUNCT[1] ? ZERO : MIN_S);
`else
    assign early_s     = 1'b0;
    assign early_val_s = ZERO;
`endif

    // Sign correction; a zero divisor keeps the all-ones quotient unnegated.
    always_comb begin
        q_fix_s = quo_r;
        r_fix_s = rem_r;
        if ((neg_a_r ^ neg_b_r) && (dvs_r != ZERO)) begin
            q_fix_s = -quo_r;
        end else begin
            q_fix_s = quo_r;
        end
        if (neg_a_r) begin
            r_fix_s = -rem_r;
        end else begin
            r_fix_s = rem_r;
        end
        fix_sel_s = funct_r[1] ? r_fix_s : q_fix_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = early_s ? S_DONE : S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX:   state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; quo_r carries the corrected result from FIX to DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rem_r    <= ZERO;
            quo_r    <= ZERO;
            dvs_r    <= ZERO;
            result_r <= ZERO;
            rd_r     <= {ADDR_WIDTH{1'b0}};
            rd_out_r <= {ADDR_WIDTH{1'b0}};
            funct_r  <= 2'b00;
            cnt_r    <= {CW{1'b0}};
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_r == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        funct_r <= bus.FUNCT;
                        rd_r    <= bus.RD_IN;
                        neg_a_r <= neg_a_s;
                        neg_b_r <= neg_b_s;
                        dvs_r   <= abs_b_s;
                        rem_r   <= ZERO;
                        cnt_r   <= {CW{1'b0}};
                        quo_r   <= early_s ? early_val_s : abs_a_s;
                    end
                end
                S_CALC: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                S_FIX:  quo_r <= fix_sel_s;
                S_DONE: begin
                    result_r <= quo_r;
                    rd_out_r <= rd_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY   = busy_r;
    assign bus.DONE   = done_r;
    assign bus.WE     = done_r;
    assign bus.RD_OUT = rd_out_r;
    assign bus.RESULT = result_r;
endmodule
